divisor_norm_reg: RTL and testbench
===================================

// Module: divisor_norm_reg
// PURPOSE
//  Parametrised divisor operand register for the unsigned divider datapath.
//  Captures a divisor through a valid/ready handshake. Optionally left-normalises it
//  (MSB = 1) over several cycles and reports the shift amount.
//  Flags a zero divisor and holds the result until the divider core accepts it.
// PARAMETERS
//  WIDTH  32  divisor width in bits; legal range >= 2
//  STEP   1   max bits shifted per NORM cycle; legal values 1, 2, 4, 8; must be <= WIDTH
//  SHW    $clog2(WIDTH)+1  width of out_shamt (derived; do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      divisor offered on in_data
//  in_ready   out  1      block can accept a divisor
//  in_data    in   WIDTH  unsigned divisor
//  in_norm    in   1      sampled with in_data: 1 = normalise, 0 = raw latch
//  out_valid  out  1      out_* fields hold a completed divisor
//  out_ready  in   1      divider core consumes the held divisor
//  out_data   out  WIDTH  divisor; normalised when in_norm was 1
//  out_shamt  out  SHW    total left shift applied (0 in raw mode)
//  out_zero   out  1      captured divisor was 0
//  busy       out  1      state == NORM
// BEHAVIOUR
//  - States: IDLE, NORM, HOLD. All outputs except in_ready are registered.
//  - in_ready = (state == IDLE) && !rst. in_valid is ignored in NORM and HOLD; there is no bypass.
//  - Reset (any time, including mid-NORM or HOLD), taking effect immediately:
//    state = IDLE, out_data = 0, out_shamt = 0, out_zero = 0, out_valid = 0, busy = 0.
//  - IDLE, on in_valid && in_ready:
//    - out_data <= in_data; out_shamt <= 0; out_zero <= (in_data == 0).
//    - Next state:
//      - in_data == 0 -> HOLD (regardless of in_norm; data = 0, shamt = 0).
//      - in_norm == 0 or in_data[WIDTH-1] == 1 -> HOLD.
//      - otherwise -> NORM.
//  - NORM, each cycle:
//    - lz = leading zeros of out_data; k = min(STEP, lz).
//    - out_data <= out_data << k; out_shamt <= out_shamt + k.
//    - If lz <= STEP -> HOLD, else stay in NORM.
//    - NORM lasts exactly ceil(lz0 / STEP) cycles, where lz0 = leading zeros of the captured value.
//  - HOLD: out_valid = 1; out_data, out_shamt and out_zero are stable.
//    - On out_ready -> IDLE: out_valid falls and in_ready rises on the next cycle.
//  - Latency from the accepting edge to out_valid high:
//    - 1 cycle (raw mode, zero divisor, or MSB already set);
//    - 1 + ceil(lz0 / STEP) cycles (normalise mode).
//  - In IDLE, out_data, out_shamt and out_zero retain the last result until the next load.
//  - out_shamt never exceeds WIDTH-1; the shift arithmetic is unsigned with no wrap.
//  - out_ready outside HOLD has no effect.
//  - Illegal parameter values are rejected at elaboration.
// TESTING
//  1. WIDTH=32, STEP=1, raw load 0x0000_0013
//     -> next cycle out_valid=1, out_data=0x0000_0013, out_shamt=0, out_zero=0.
//  2. STEP=1, normalise load 0x0000_0013
//     -> busy for 27 cycles, then out_data=0x9800_0000, out_shamt=27.
//  3. STEP=4, normalise load 0x0000_0013
//     -> busy for 7 cycles, then out_data=0x9800_0000, out_shamt=27.
//  4. Normalise load 0x8000_0001 -> HOLD after 1 cycle with shamt=0.
//     Load 0x0 with in_norm=1 -> out_zero=1, out_data=0, out_shamt=0, no NORM cycles.
//  5. In HOLD, out_ready=0 for 10 cycles while in_valid pulses 0x5
//     -> in_ready=0, outputs unchanged. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  6. Assert rst asynchronously mid-NORM
//     -> outputs zero at once, busy=0, state IDLE.
//     After release, load 0x1 (normalise) -> out_data=0x8000_0000, out_shamt=31.

Source files
------------

// File: rtl/divisor_norm_reg.sv
// Divisor operand register: accepts a divisor over valid/ready, optionally
// left-normalises it STEP bits per cycle, and holds the result for the divider core.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a divisor; last result still visible on out_*
//   NORM  | shifting out_data left until its MSB is set
//   HOLD  | result valid; waiting for out_ready
module divisor_norm_reg #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_norm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_zero,
    output logic             busy
);

    if (WIDTH < 2 || !(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || STEP > WIDTH ||
        SHW != $clog2(WIDTH) + 1) begin : g_bad_param
        $error("divisor_norm_reg: illegal WIDTH/STEP/SHW");
    end

    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [SHW-1:0]   lz;
    logic [SHW-1:0]   k;

    function automatic logic [SHW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [SHW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + SHW'(1);
            end
        end
        return n;
    endfunction

    // NORM is only entered with a nonzero value, so lz stays below WIDTH there.
    always_comb begin
        lz = count_lz(data_q);
        k  = (lz < STEP_W) ? lz : STEP_W;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    shamt_d = '0;
                    zero_d  = (in_data == '0);
                    if (in_data == '0 || !in_norm || in_data[WIDTH-1]) state_d = HOLD;
                    else                                               state_d = NORM;
                end
            end
            NORM: begin
                data_d  = data_q << k;
                shamt_d = shamt_q + k;
                if (lz <= STEP_W) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == HOLD);
        busy_d  = (state_d == NORM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_zero  = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_divisor_norm_reg.sv
// Directed bench for divisor_norm_reg: one instance with STEP=1 and one with STEP=4
// share the stimulus; expected values are hand-computed in the vector table.
module tb_divisor_norm_reg;
    localparam int W   = 32;
    localparam int SHW = $clog2(W) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_norm;
    logic           out_ready;

    logic           in_ready1, out_valid1, out_zero1, busy1;
    logic [W-1:0]   out_data1;
    logic [SHW-1:0] out_shamt1;
    logic           in_ready4, out_valid4, out_zero4, busy4;
    logic [W-1:0]   out_data4;
    logic [SHW-1:0] out_shamt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divisor_norm_reg #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_norm(in_norm), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_shamt(out_shamt1),
        .out_zero(out_zero1), .busy(busy1)
    );

    divisor_norm_reg #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_norm(in_norm), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_shamt(out_shamt4),
        .out_zero(out_zero4), .busy(busy4)
    );

    typedef struct {
        logic [W-1:0]   data;
        logic           norm;
        logic [W-1:0]   exp_data;
        logic [SHW-1:0] exp_shamt;
        logic           exp_zero;
        int             nbusy1;
        int             nbusy4;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat1, lat4, nb1, nb4;
        lat1 = 0; lat4 = 0; nb1 = 0; nb4 = 0;
        check({tag, " in_ready1 idle"}, 64'(in_ready1), 64'(1));
        check({tag, " in_ready4 idle"}, 64'(in_ready4), 64'(1));
        in_valid = 1'b1;
        in_data  = v.data;
        in_norm  = v.norm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int cyc = 1; cyc <= 64 && (lat1 == 0 || lat4 == 0); cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            if (lat1 == 0) begin
                if (out_valid1) lat1 = cyc;
                else if (busy1) nb1++;
            end
            if (lat4 == 0) begin
                if (out_valid4) lat4 = cyc;
                else if (busy4) nb4++;
            end
        end
        check({tag, " latency s1"}, 64'(lat1), 64'(v.nbusy1 + 1));
        check({tag, " latency s4"}, 64'(lat4), 64'(v.nbusy4 + 1));
        check({tag, " busy cycles s1"}, 64'(nb1), 64'(v.nbusy1));
        check({tag, " busy cycles s4"}, 64'(nb4), 64'(v.nbusy4));
        check({tag, " data s1"},  64'(out_data1),  64'(v.exp_data));
        check({tag, " data s4"},  64'(out_data4),  64'(v.exp_data));
        check({tag, " shamt s1"}, 64'(out_shamt1), 64'(v.exp_shamt));
        check({tag, " shamt s4"}, 64'(out_shamt4), 64'(v.exp_shamt));
        check({tag, " zero s1"},  64'(out_zero1),  64'(v.exp_zero));
        check({tag, " zero s4"},  64'(out_zero4),  64'(v.exp_zero));
        check({tag, " in_ready1 hold"}, 64'(in_ready1), 64'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " valid1 drop"}, 64'(out_valid1), 64'(0));
        check({tag, " valid4 drop"}, 64'(out_valid4), 64'(0));
        check({tag, " in_ready1 back"}, 64'(in_ready1), 64'(1));
        check({tag, " in_ready4 back"}, 64'(in_ready4), 64'(1));
        check({tag, " data1 retained"}, 64'(out_data1), 64'(v.exp_data));
    endtask

    initial begin
        //         data          norm  exp_data      shamt zero  s1  s4
        vecs[0] = '{32'h0000_0013, 1'b0, 32'h0000_0013, 6'd0,  1'b0, 0,  0};
        vecs[1] = '{32'h0000_0013, 1'b1, 32'h9800_0000, 6'd27, 1'b0, 27, 7};
        vecs[2] = '{32'h8000_0001, 1'b1, 32'h8000_0001, 6'd0,  1'b0, 0,  0};
        vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd0,  1'b1, 0,  0};
        vecs[4] = '{32'h0000_0001, 1'b1, 32'h8000_0000, 6'd31, 1'b0, 31, 8};
        vecs[5] = '{32'h4000_0000, 1'b1, 32'h8000_0000, 6'd1,  1'b0, 1,  1};
        vecs[6] = '{32'h0F00_0000, 1'b1, 32'hF000_0000, 6'd4,  1'b0, 4,  1};
        vecs[7] = '{32'h00F0_0000, 1'b1, 32'hF000_0000, 6'd8,  1'b0, 8,  2};
        vecs[8] = '{32'h0001_0000, 1'b0, 32'h0001_0000, 6'd0,  1'b0, 0,  0};
        vecs[9] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd0,  1'b1, 0,  0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_norm   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset in_ready1", 64'(in_ready1), 64'(0));
        check("reset out_valid1", 64'(out_valid1), 64'(0));
        check("reset busy4", 64'(busy4), 64'(0));
        check("reset data1", 64'(out_data1), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // HOLD ignores new offers and stays put until out_ready.
        in_valid = 1'b1;
        in_data  = 32'h0000_0013;
        in_norm  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold entry valid1", 64'(out_valid1), 64'(1));
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = 32'h0000_0005;
            in_norm  = 1'b1;
            @(posedge clk); #1;
            check($sformatf("hold%0d in_ready1", c), 64'(in_ready1), 64'(0));
            check($sformatf("hold%0d valid1", c), 64'(out_valid1), 64'(1));
            check($sformatf("hold%0d data1", c), 64'(out_data1), 64'(32'h13));
            check($sformatf("hold%0d data4", c), 64'(out_data4), 64'(32'h13));
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release valid1", 64'(out_valid1), 64'(0));
        check("release in_ready1", 64'(in_ready1), 64'(1));
        check("release data retained", 64'(out_data1), 64'(32'h13));
        @(posedge clk); #1;
        check("out_ready idle no effect valid", 64'(out_valid1), 64'(0));
        check("out_ready idle in_ready", 64'(in_ready1), 64'(1));
        out_ready = 1'b0;

        // Asynchronous reset in the middle of normalisation.
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_norm  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midnorm busy1", 64'(busy1), 64'(1));
        check("midnorm busy4", 64'(busy4), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async rst data1", 64'(out_data1), 64'(0));
        check("async rst shamt1", 64'(out_shamt1), 64'(0));
        check("async rst shamt4", 64'(out_shamt4), 64'(0));
        check("async rst busy1", 64'(busy1), 64'(0));
        check("async rst busy4", 64'(busy4), 64'(0));
        check("async rst valid1", 64'(out_valid1), 64'(0));
        check("async rst zero1", 64'(out_zero1), 64'(0));
        check("async rst in_ready1", 64'(in_ready1), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post rst in_ready1", 64'(in_ready1), 64'(1));
        check("post rst in_ready4", 64'(in_ready4), 64'(1));
        run_vec(vecs[4], "after rst 0x1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
